// File: rtl/pipeline_hazard_scheduler_if.sv
// Decode-stage handshake between the ID stage (master) and the hazard/flush scheduler (slave).
interface pipeline_hazard_scheduler_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IR;
    logic             id_valid;
    logic             ex_redirect;
    logic             stall;
    logic             bubble;
    logic             flush_if;
    logic             issue;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output IR, id_valid, ex_redirect,
        input  stall, bubble, flush_if, issue, state, stall_cycles
    );

    modport slave (
        input  IR, id_valid, ex_redirect,
        output stall, bubble, flush_if, issue, state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_scheduler.sv
// Issue scheduler beside decode: scoreboards pending write-backs, stalls on RAW hazards
// (no forwarding) and sequences the IF/ID flush after a redirect resolves in EX.
module pipeline_hazard_scheduler #(
    parameter int WB_LAT    = 3,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input logic                        clk,
    input logic                        rst,
    pipeline_hazard_scheduler_if.slave bus
);
    localparam int SB_W = $clog2(WB_LAT + 1);
    localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [SB_W-1:0]  SB_LOAD = SB_W'(WB_LAT);
    localparam logic [SB_W-1:0]  SB_ZERO = {SB_W{1'b0}};
    localparam logic [FL_W-1:0]  FL_LOAD = FL_W'(FLUSH_CYC - 1);
    localparam logic [FL_W-1:0]  FL_ZERO = {FL_W{1'b0}};
    localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
    localparam logic [CNT_W-1:0] SC_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dest;
    } dec_t;

    // A zero dest means "no write-back"; $0 is never tracked.
    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d.use_rs = 1'b0;
        d.use_rt = 1'b0;
        d.dest   = 5'd0;
        case (ir[31:26])
            6'd0: begin
                case (ir[5:0])
                    6'd32, 6'd34, 6'd42: begin
                        d.use_rs = 1'b1;
                        d.use_rt = 1'b1;
                        d.dest   = ir[15:11];
                    end
                    default: d.dest = 5'd0;
                endcase
            end
            6'd35: begin
                d.use_rs = 1'b1;
                d.dest   = ir[20:16];
            end
            6'd43, 6'd4, 6'd5: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            default: d.dest = 5'd0;
        endcase
        return d;
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [FL_W-1:0]  flush_cnt_r;
    logic [FL_W-1:0]  flush_cnt_nx_s;
    logic [SB_W-1:0]  sb_cnt_r [32];
    logic [CNT_W-1:0] stall_cycles_r;

    dec_t       dec_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic       rs_busy_s;
    logic       rt_busy_s;
    logic       hazard_s;
    logic       stall_s;
    logic       bubble_s;
    logic       flush_s;
    logic       issue_s;
    logic       count_s;

    assign dec_s     = decode(bus.IR);
    assign rs_s      = bus.IR[25:21];
    assign rt_s      = bus.IR[20:16];
    assign rs_busy_s = dec_s.use_rs && (rs_s != 5'd0) && (sb_cnt_r[rs_s] != SB_ZERO);
    assign rt_busy_s = dec_s.use_rt && (rt_s != 5'd0) && (sb_cnt_r[rt_s] != SB_ZERO);
    assign hazard_s  = bus.id_valid && (rs_busy_s || rt_busy_s);

    // FSM state register and flush-window counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= FL_ZERO;
        end else begin
            state_r     <= state_nx_s;
            flush_cnt_r <= flush_cnt_nx_s;
        end
    end

    // Next-state logic: a redirect always wins and (re)opens the flush window
    always_comb begin
        state_nx_s     = state_r;
        flush_cnt_nx_s = flush_cnt_r;
        case (state_r)
            ST_RUN, ST_HAZARD: begin
                if (bus.ex_redirect) begin
                    state_nx_s     = (FLUSH_CYC > 1) ? ST_REDIRECT : ST_RUN;
                    flush_cnt_nx_s = FL_LOAD;
                end else if (hazard_s) begin
                    state_nx_s     = ST_HAZARD;
                    flush_cnt_nx_s = FL_ZERO;
                end else begin
                    state_nx_s     = ST_RUN;
                    flush_cnt_nx_s = FL_ZERO;
                end
            end
            ST_REDIRECT: begin
                if (bus.ex_redirect) begin
                    state_nx_s     = (FLUSH_CYC > 1) ? ST_REDIRECT : ST_RUN;
                    flush_cnt_nx_s = FL_LOAD;
                end else if (flush_cnt_r <= FL_ONE) begin
                    state_nx_s     = ST_RUN;
                    flush_cnt_nx_s = FL_ZERO;
                end else begin
                    state_nx_s     = ST_REDIRECT;
                    flush_cnt_nx_s = flush_cnt_r - FL_ONE;
                end
            end
            default: begin
                state_nx_s     = ST_RUN;
                flush_cnt_nx_s = FL_ZERO;
            end
        endcase
    end

    // Output decode from current state and live decode inputs
    always_comb begin
        stall_s  = 1'b0;
        bubble_s = 1'b1;
        flush_s  = 1'b0;
        issue_s  = 1'b0;
        count_s  = 1'b0;
        case (state_r)
            ST_RUN, ST_HAZARD: begin
                if (bus.ex_redirect) begin
                    flush_s = 1'b1;
                end else if (hazard_s) begin
                    stall_s = 1'b1;
                    count_s = 1'b1;
                end else begin
                    issue_s  = bus.id_valid;
                    bubble_s = ~bus.id_valid;
                end
            end
            ST_REDIRECT: begin
                flush_s = 1'b1;
            end
            default: begin
                flush_s = 1'b0;
            end
        endcase
    end

    // Pending write-back countdown per register; a fresh issue overrides the decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                sb_cnt_r[i] <= SB_ZERO;
            end
        end else begin
            sb_cnt_r[0] <= SB_ZERO;
            for (int i = 1; i < 32; i++) begin
                if (issue_s && (dec_s.dest == 5'(i))) begin
                    sb_cnt_r[i] <= SB_LOAD;
                end else if (sb_cnt_r[i] != SB_ZERO) begin
                    sb_cnt_r[i] <= sb_cnt_r[i] - SB_W'(1);
                end else begin
                    sb_cnt_r[i] <= sb_cnt_r[i];
                end
            end
        end
    end

    // Saturating hazard-stall performance counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (count_s && (stall_cycles_r != SC_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign bus.stall        = stall_s;
    assign bus.bubble       = bubble_s;
    assign bus.flush_if     = flush_s;
    assign bus.issue        = issue_s;
    assign bus.state        = state_r;
    assign bus.stall_cycles = stall_cycles_r;
endmodule

// File: tb/tb_pipeline_hazard_scheduler.sv
// Directed + randomized bench for pipeline_hazard_scheduler against a time-based reference model
// (per-register "ready at edge N" and a flush window end edge).
module tb_pipeline_hazard_scheduler;
    localparam int WB_LAT    = 3;
    localparam int FLUSH_CYC = 2;
    localparam int CNT_W     = 16;
    localparam int unsigned SC_SAT = (32'd1 << CNT_W) - 32'd1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_hazard_scheduler_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_scheduler #(
        .WB_LAT   (WB_LAT),
        .FLUSH_CYC(FLUSH_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    int unsigned edge_n = 0;
    int unsigned flush_until = 0;
    int unsigned sc_m = 0;
    int unsigned pend [32];
    bit          last_stall = 1'b0;

    bit          e_stall, e_bub, e_fl, e_iss;
    int          e_dst;
    int unsigned e_state;

    function automatic logic [31:0] rtype(input int funct, input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0010};
    endfunction

    task automatic mdecode(input logic [31:0] ir, output bit use_rs, output bit use_rt, output int dst);
        int op;
        int fn;
        op = int'(ir[31:26]);
        fn = int'(ir[5:0]);
        use_rs = 1'b0;
        use_rt = 1'b0;
        dst    = 0;
        if (op == 0 && (fn == 32 || fn == 34 || fn == 42)) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
            dst    = int'(ir[15:11]);
        end else if (op == 35) begin
            use_rs = 1'b1;
            dst    = int'(ir[20:16]);
        end else if (op == 43 || op == 4 || op == 5) begin
            use_rs = 1'b1;
            use_rt = 1'b1;
        end
    endtask

    function automatic bit busy(input int r);
        return (r != 0) && (edge_n < pend[r]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        flush_until = 0;
        sc_m        = 0;
        last_stall  = 1'b0;
    endtask

    task automatic evaluate();
        bit urs, urt, haz, redir_win;
        int rs, rt;
        mdecode(bus.IR, urs, urt, e_dst);
        rs = int'(bus.IR[25:21]);
        rt = int'(bus.IR[20:16]);
        haz = bus.id_valid && ((urs && busy(rs)) || (urt && busy(rt)));
        redir_win = edge_n < flush_until;
        e_state = redir_win ? 2 : (last_stall ? 1 : 0);
        e_stall = 1'b0;
        e_fl    = 1'b0;
        e_iss   = 1'b0;
        e_bub   = 1'b1;
        if (bus.ex_redirect || redir_win) begin
            e_fl = 1'b1;
        end else if (haz) begin
            e_stall = 1'b1;
        end else begin
            e_iss = bus.id_valid;
            e_bub = !bus.id_valid;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ctx);
        evaluate();
        chk({ctx, ".stall"},        32'(bus.stall),        32'(e_stall));
        chk({ctx, ".bubble"},       32'(bus.bubble),       32'(e_bub));
        chk({ctx, ".flush_if"},     32'(bus.flush_if),     32'(e_fl));
        chk({ctx, ".issue"},        32'(bus.issue),        32'(e_iss));
        chk({ctx, ".state"},        32'(bus.state),        e_state);
        chk({ctx, ".stall_cycles"}, 32'(bus.stall_cycles), sc_m);
    endtask

    // One pipeline cycle: drive just after an edge, sample at negedge, advance model at the edge.
    task automatic step(input string ctx, input logic [31:0] ir, input bit v, input bit rd);
        bus.IR          = ir;
        bus.id_valid    = v;
        bus.ex_redirect = rd;
        @(negedge clk);
        check_outputs(ctx);
        @(posedge clk);
        if (rd) flush_until = edge_n + FLUSH_CYC;
        if (e_iss && e_dst != 0) pend[e_dst] = edge_n + 1 + WB_LAT;
        last_stall = e_stall;
        if (e_stall && sc_m < SC_SAT) sc_m++;
        edge_n++;
        #1;
    endtask

    task automatic reset_pulse(input string ctx);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(ctx);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_ir();
        int k, rs, rt, rd;
        k  = int'($urandom_range(0, 9));
        rs = int'($urandom_range(0, 7));
        rt = int'($urandom_range(0, 7));
        rd = int'($urandom_range(0, 7));
        case (k)
            0:       return rtype(32, rs, rt, rd);
            1:       return rtype(34, rs, rt, rd);
            2:       return rtype(42, rs, rt, rd);
            3:       return itype(35, rs, rt);
            4:       return itype(43, rs, rt);
            5:       return itype(4, rs, rt);
            6:       return itype(5, rs, rt);
            7:       return itype(2, rs, rt);
            8:       return itype(63, rs, rt);
            default: return rtype(0, rs, rt, rd);
        endcase
    endfunction

    initial begin
        logic [31:0] add_dep;
        model_reset();
        bus.IR          = 32'd0;
        bus.id_valid    = 1'b0;
        bus.ex_redirect = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: lw $3 then dependent add -> three stall cycles, issue on the fourth
        add_dep = rtype(32, 3, 5, 4);
        step("t1_lw", itype(35, 1, 3), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("t1_add", add_dep, 1'b1, 1'b0);
        chk("t1_stall_cycles", 32'(bus.stall_cycles), 32'd3);

        // 2: independent back-to-back ALU ops
        step("t2_add", rtype(32, 1, 2, 3), 1'b1, 1'b0);
        step("t2_sub", rtype(34, 7, 8, 6), 1'b1, 1'b0);
        step("t2_idle", 32'd0, 1'b0, 1'b0);

        // 3: redirect while a hazard is pending; squashed add must not mark $10
        step("t3_lw", itype(35, 1, 9), 1'b1, 1'b0);
        step("t3_redir", rtype(32, 9, 9, 10), 1'b1, 1'b1);
        step("t3_flush", rtype(32, 9, 9, 10), 1'b1, 1'b0);
        step("t3_use10", rtype(32, 10, 0, 11), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("t3_drain", 32'd0, 1'b0, 1'b0);

        // 4: $0 never creates a hazard; sw stalls on rt
        step("t4_add0", rtype(32, 1, 2, 0), 1'b1, 1'b0);
        step("t4_read0", rtype(32, 0, 0, 5), 1'b1, 1'b0);
        step("t4_lw", itype(35, 2, 3), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step("t4_sw", itype(43, 2, 3), 1'b1, 1'b0);

        // 5: unknown opcode is a NOP
        step("t5_lw", itype(35, 1, 3), 1'b1, 1'b0);
        step("t5_op63", itype(63, 3, 3), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("t5_drain", 32'd0, 1'b0, 1'b0);

        // 6: async reset mid-hazard, then the dependent add issues at once
        step("t6_lw", itype(35, 1, 3), 1'b1, 1'b0);
        step("t6_stall", add_dep, 1'b1, 1'b0);
        reset_pulse("t6_rst");
        chk("t6_rst_state", 32'(bus.state), 32'd0);
        step("t6_issue", add_dep, 1'b1, 1'b0);
        chk("t6_stall_cycles", 32'(bus.stall_cycles), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse("rnd_rst");
            end
            step("rnd", rand_ir(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 11) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
